// File: rtl/neuron_sched.sv
// rtl/neuron_sched.sv - per-tick neuron address sweep with single-slot host access arbitration
// Optional: define NEURON_SCHED_EXT_PREEMPT_EN to let host requests pause an active sweep.
module neuron_sched #(
   parameter int NEURON_NO = 3072,
   parameter int EXT_AW    = 8,
   localparam int NA_W     = (NEURON_NO > 1) ? $clog2(NEURON_NO) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sys_en,
   input  logic              dt_tick,
   input  logic [1:0]        ext_req,
   input  logic [EXT_AW-1:0] ext_addr,
   input  logic              ovr_clr,
   output logic              en,
   output logic [NA_W-1:0]   n_addr,
   output logic              ext_re,
   output logic              ext_we,
   output logic [EXT_AW-1:0] ext_mem_addr,
   output logic              ext_ack,
   output logic              sweep_done,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, SWEEP, EXT, ACK} state_t;

   localparam logic [NA_W-1:0] LAST = NA_W'(NEURON_NO - 1);

   state_t state, state_d;

   logic              en_d, re_d, we_d, ack_d, done_d, busy_d, ovr_d, ovr_set;
   logic [NA_W-1:0]   n_addr_d;
   logic [EXT_AW-1:0] mem_addr_d;
   logic              pend, pend_d;
   logic              ign, ign_d;
   logic              resume, resume_d;
   logic              tick, host_req;

   assign tick = dt_tick & sys_en;
   // ign masks a request the host may still be holding in the cycle right after its ack
   assign host_req = ((ext_req == 2'd1) || (ext_req == 2'd2)) && !ign;

   always_comb begin
      state_d    = state;
      en_d       = 1'b0;
      n_addr_d   = n_addr;
      re_d       = 1'b0;
      we_d       = 1'b0;
      mem_addr_d = ext_mem_addr;
      ack_d      = 1'b0;
      done_d     = 1'b0;
      pend_d     = pend;
      ign_d      = 1'b0;
      resume_d   = resume;
      ovr_set    = 1'b0;
      case (state)
         IDLE: begin
            if (tick || pend) begin
               state_d  = SWEEP;
               en_d     = 1'b1;
               n_addr_d = '0;
               pend_d   = 1'b0;
            end else if (host_req) begin
               state_d    = EXT;
               mem_addr_d = ext_addr;
               re_d       = (ext_req == 2'd1);
               we_d       = (ext_req == 2'd2);
            end
         end
         SWEEP: begin
            ovr_set = dt_tick;
            if (n_addr == LAST) begin
               state_d  = IDLE;
               n_addr_d = '0;
               done_d   = 1'b1;
            end
`ifdef NEURON_SCHED_EXT_PREEMPT_EN
            else if (host_req) begin
               // n_addr holds the last swept address; resume picks up at n_addr+1
               state_d    = EXT;
               resume_d   = 1'b1;
               mem_addr_d = ext_addr;
               re_d       = (ext_req == 2'd1);
               we_d       = (ext_req == 2'd2);
            end
`endif
            else begin
               en_d     = 1'b1;
               n_addr_d = n_addr + NA_W'(1);
            end
         end
         EXT: begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (resume) ovr_set = dt_tick;
            else if (tick) pend_d = 1'b1;
         end
         ACK: begin
            ign_d = 1'b1;
            if (resume) ovr_set = dt_tick;
            else if (tick) pend_d = 1'b1;
            if (resume) begin
               state_d  = SWEEP;
               en_d     = 1'b1;
               n_addr_d = n_addr + NA_W'(1);
               resume_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      ovr_d  = ovr_set | (overrun & ~ovr_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         en           <= 1'b0;
         n_addr       <= '0;
         ext_re       <= 1'b0;
         ext_we       <= 1'b0;
         ext_mem_addr <= '0;
         ext_ack      <= 1'b0;
         sweep_done   <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         pend         <= 1'b0;
         ign          <= 1'b0;
         resume       <= 1'b0;
      end else begin
         state        <= state_d;
         en           <= en_d;
         n_addr       <= n_addr_d;
         ext_re       <= re_d;
         ext_we       <= we_d;
         ext_mem_addr <= mem_addr_d;
         ext_ack      <= ack_d;
         sweep_done   <= done_d;
         busy         <= busy_d;
         overrun      <= ovr_d;
         pend         <= pend_d;
         ign          <= ign_d;
         resume       <= resume_d;
      end
   end

endmodule

// File: tb/tb_neuron_sched.sv
// tb/tb_neuron_sched.sv - randomized self-checking bench for neuron_sched (NEURON_NO=8)
module tb_neuron_sched;

   localparam int N  = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sys_en = 1'b0;
   logic          dt_tick = 1'b0;
   logic [1:0]    ext_req = 2'd0;
   logic [AW-1:0] ext_addr = '0;
   logic          ovr_clr = 1'b0;
   logic          en, ext_re, ext_we, ext_ack, sweep_done, busy, overrun;
   logic [2:0]    n_addr;
   logic [AW-1:0] ext_mem_addr;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   neuron_sched #(.NEURON_NO(N), .EXT_AW(AW)) dut (
      .clk(clk), .reset(reset), .sys_en(sys_en), .dt_tick(dt_tick),
      .ext_req(ext_req), .ext_addr(ext_addr), .ovr_clr(ovr_clr),
      .en(en), .n_addr(n_addr), .ext_re(ext_re), .ext_we(ext_we),
      .ext_mem_addr(ext_mem_addr), .ext_ack(ext_ack), .sweep_done(sweep_done),
      .busy(busy), .overrun(overrun)
   );

   always @(negedge clk) begin
      if (reset) begin
         checks++;
         assert (int'(en) + int'(ext_re) + int'(ext_we) <= 1)
         else begin
            fails++;
            $display("FAIL mutex: en=%0b re=%0b we=%0b, at most one required", en, ext_re, ext_we);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] outs();
      return {en, n_addr, ext_re, ext_we, ext_mem_addr, ext_ack, sweep_done, busy, overrun};
   endfunction

   task automatic test_reset();
      bit found;
      reset = 1'b0;
      repeat (3) step();
      checks++;
      if (outs() !== 18'd0) begin
         fails++; $display("FAIL reset_state: outs=%h required 0", outs());
      end
      reset = 1'b1;
      step();
      sys_en = 1'b1; dt_tick = 1'b1;
      found = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         step();
         dt_tick = (k == 3);
         if (en && n_addr == 3'd5) found = 1'b1;
      end
      dt_tick = 1'b0;
      checks++;
      if (!found || overrun !== 1'b1) begin
         fails++; $display("FAIL reset_setup: reached n_addr5=%0b overrun=%0b required 1/1", found, overrun);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (outs() !== 18'd0) begin
         fails++; $display("FAIL reset_async: outs=%h required 0", outs());
      end
      step();
      reset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         checks++;
         if ({en, sweep_done, busy} !== 3'b000) begin
            fails++; $display("FAIL reset_quiet: en/done/busy=%b required 000 (cycle %0d)", {en, sweep_done, busy}, k);
         end
      end
   endtask

   task automatic test_sweep();
      for (int it = 0; it < 4; it++) begin
         int  gap;
         bit  drop;
         gap  = $urandom_range(0, 5);
         drop = 1'($urandom_range(0, 1));
         repeat (gap) step();
         sys_en = 1'b1; dt_tick = 1'b1;
         step();
         dt_tick = 1'b0;
         for (int k = 1; k <= N + 3; k++) begin
            if (drop && k == 3) sys_en = 1'b0;
            checks++;
            if (en !== (k <= N) || sweep_done !== (k == N + 1) || busy !== (k <= N)) begin
               fails++;
               $display("FAIL sweep_ctl: k=%0d en=%0b done=%0b busy=%0b required %0b/%0b/%0b",
                        k, en, sweep_done, busy, k <= N, k == N + 1, k <= N);
            end
            checks++;
            if (n_addr !== ((k <= N) ? 3'(k - 1) : 3'd0)) begin
               fails++; $display("FAIL sweep_addr: k=%0d n_addr=%0d required %0d", k, n_addr, (k <= N) ? k - 1 : 0);
            end
            step();
         end
      end
      sys_en = 1'b0; dt_tick = 1'b1;
      step();
      dt_tick = 1'b0;
      for (int k = 1; k <= N + 2; k++) begin
         checks++;
         if (en !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL sweep_disabled: en=%0b busy=%0b required 0/0", en, busy);
         end
         step();
      end
      sys_en = 1'b1;
   endtask

   task automatic test_host();
      for (int it = 0; it < 6; it++) begin
         logic [1:0]    req;
         logic [AW-1:0] addr;
         bit            legal;
         req   = 2'($urandom_range(1, 3));
         addr  = AW'($urandom);
         legal = (req != 2'd3);
         ext_req = req; ext_addr = addr;
         step();
         ext_addr = AW'($urandom);
         checks++;
         if (ext_re !== (req == 2'd1) || ext_we !== (req == 2'd2) || ext_ack !== 1'b0 || busy !== legal) begin
            fails++;
            $display("FAIL host_strobe: req=%0d re=%0b we=%0b ack=%0b busy=%0b", req, ext_re, ext_we, ext_ack, busy);
         end
         if (legal) begin
            checks++;
            if (ext_mem_addr !== addr) begin
               fails++; $display("FAIL host_addr: ext_mem_addr=%h required %h", ext_mem_addr, addr);
            end
         end
         step();
         checks++;
         if (ext_ack !== legal || ext_re !== 1'b0 || ext_we !== 1'b0) begin
            fails++; $display("FAIL host_ack: req=%0d ack=%0b re=%0b we=%0b required ack=%0b", req, ext_ack, ext_re, ext_we, legal);
         end
         ext_req = 2'd0;
         step();
         checks++;
         if ({ext_ack, busy, ext_re, ext_we} !== 4'b0000) begin
            fails++; $display("FAIL host_idle: ack/busy/re/we=%b required 0000", {ext_ack, busy, ext_re, ext_we});
         end
         step();
      end
      for (int it = 0; it < 2; it++) begin
         int drop;
         drop = 4 + it;
         ext_req = 2'd1; ext_addr = AW'($urandom);
         for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (ext_re !== (k == 1 || (drop >= 5 && k == 5)) ||
                ext_ack !== (k == 2 || (drop >= 5 && k == 6))) begin
               fails++; $display("FAIL host_hold: drop=%0d k=%0d re=%0b ack=%0b", drop, k, ext_re, ext_ack);
            end
            if (k == drop) ext_req = 2'd0;
         end
      end
   endtask

   task automatic test_collision();
      int            exp_a [64];
      int            re_k, ack_k, done_k;
      logic [AW-1:0] addr;
      addr = AW'($urandom);
      for (int i = 0; i < 64; i++) exp_a[i] = -1;
`ifdef NEURON_SCHED_EXT_PREEMPT_EN
      re_k = 2; ack_k = 3; done_k = N + 3;
      exp_a[1] = 0;
      for (int a = 1; a < N; a++) exp_a[a + 3] = a;
`else
      re_k = N + 2; ack_k = N + 3; done_k = N + 1;
      for (int a = 0; a < N; a++) exp_a[a + 1] = a;
`endif
      sys_en = 1'b1; dt_tick = 1'b1; ext_req = 2'd1; ext_addr = addr;
      step();
      dt_tick = 1'b0;
      for (int k = 1; k <= N + 5; k++) begin
         checks++;
         if (en !== (exp_a[k] >= 0) || (exp_a[k] >= 0 && n_addr !== 3'(exp_a[k])) ||
             ext_re !== (k == re_k) || ext_ack !== (k == ack_k) || sweep_done !== (k == done_k)) begin
            fails++;
            $display("FAIL collide_tick_req: k=%0d en=%0b n_addr=%0d re=%0b ack=%0b done=%0b required addr=%0d re=%0b ack=%0b done=%0b",
                     k, en, n_addr, ext_re, ext_ack, sweep_done, exp_a[k], k == re_k, k == ack_k, k == done_k);
         end
         if (k == re_k) begin
            checks++;
            if (ext_mem_addr !== addr) begin
               fails++; $display("FAIL collide_addr: ext_mem_addr=%h required %h", ext_mem_addr, addr);
            end
         end
         if (k == ack_k) ext_req = 2'd0;
         step();
      end
      for (int i = 0; i < 64; i++) exp_a[i] = -1;
      for (int a = 0; a < N; a++) exp_a[a + 4] = a;
      ext_req = 2'd2; ext_addr = AW'($urandom);
      step();
      dt_tick = 1'b1;
      checks++;
      if (ext_we !== 1'b1) begin
         fails++; $display("FAIL collide_ext_we: we=%0b required 1", ext_we);
      end
      step();
      dt_tick = 1'b0; ext_req = 2'd0;
      for (int k = 2; k <= N + 6; k++) begin
         checks++;
         if (en !== (exp_a[k] >= 0) || (exp_a[k] >= 0 && n_addr !== 3'(exp_a[k])) ||
             ext_ack !== (k == 2) || sweep_done !== (k == N + 4) || overrun !== 1'b0) begin
            fails++;
            $display("FAIL collide_tick_in_ext: k=%0d en=%0b n_addr=%0d ack=%0b done=%0b ovr=%0b required addr=%0d",
                     k, en, n_addr, ext_ack, sweep_done, overrun, exp_a[k]);
         end
         step();
      end
   endtask

   task automatic test_overrun();
      for (int it = 0; it < 2; it++) begin
         int pos;
         pos = $urandom_range(1, N - 2);
         checks++;
         if (overrun !== 1'b0) begin
            fails++; $display("FAIL ovr_start: overrun=%0b required 0", overrun);
         end
         sys_en = 1'b1; dt_tick = 1'b1;
         step();
         dt_tick = 1'b0;
         for (int k = 1; k <= N + 6; k++) begin
            checks++;
            if (en !== (k <= N) || sweep_done !== (k == N + 1) || overrun !== (k >= pos + 2)) begin
               fails++;
               $display("FAIL ovr_sweep: pos=%0d k=%0d en=%0b done=%0b ovr=%0b required %0b/%0b/%0b",
                        pos, k, en, sweep_done, overrun, k <= N, k == N + 1, k >= pos + 2);
            end
            dt_tick = (k == pos + 1);
            step();
         end
         dt_tick = 1'b0;
         ovr_clr = 1'b1;
         step();
         ovr_clr = 1'b0;
         checks++;
         if (overrun !== 1'b0) begin
            fails++; $display("FAIL ovr_clear: overrun=%0b required 0", overrun);
         end
      end
      dt_tick = 1'b1;
      step();
      dt_tick = 1'b1; ovr_clr = 1'b1;
      step();
      dt_tick = 1'b0; ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         fails++; $display("FAIL ovr_set_wins: overrun=%0b required 1", overrun);
      end
      repeat (N + 2) step();
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         fails++; $display("FAIL ovr_clear2: overrun=%0b required 0", overrun);
      end
   endtask

`ifdef NEURON_SCHED_EXT_PREEMPT_EN
   task automatic test_preempt();
      for (int it = 0; it < 3; it++) begin
         int p, first_en, last_en, re_k, ack_k, done_k;
         int seen[$];
         p = $urandom_range(0, N - 2);
         first_en = -1; last_en = -1; re_k = -1; ack_k = -1; done_k = -1;
         seen.delete();
         sys_en = 1'b1; dt_tick = 1'b1;
         step();
         dt_tick = 1'b0;
         for (int k = 1; k <= N + 6; k++) begin
            if (en) begin
               seen.push_back(int'(n_addr));
               if (first_en < 0) first_en = k;
               last_en = k;
            end
            if (ext_re && re_k < 0) re_k = k;
            if (ext_ack && ack_k < 0) begin
               ack_k = k; ext_req = 2'd0;
            end
            if (sweep_done && done_k < 0) done_k = k;
            if (en && n_addr == 3'(p) && re_k < 0) begin
               ext_req = 2'd1; ext_addr = AW'($urandom);
            end
            step();
         end
         ext_req = 2'd0;
         checks++;
         if (seen.size() != N) begin
            fails++; $display("FAIL preempt_count: en cycles=%0d required %0d", seen.size(), N);
         end
         for (int i = 0; i < seen.size() && i < N; i++) begin
            checks++;
            if (seen[i] != i) begin
               fails++; $display("FAIL preempt_order: slot %0d n_addr=%0d required %0d", i, seen[i], i);
            end
         end
         checks++;
         if (first_en != 1 || last_en != N + 2 || re_k != p + 2 || ack_k != p + 3 || done_k != N + 3) begin
            fails++;
            $display("FAIL preempt_timing: p=%0d first=%0d last=%0d re=%0d ack=%0d done=%0d required 1/%0d/%0d/%0d/%0d",
                     p, first_en, last_en, re_k, ack_k, done_k, N + 2, p + 2, p + 3, N + 3);
         end
         repeat (2) step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sweep();
      test_host();
      test_collision();
      test_overrun();
`ifdef NEURON_SCHED_EXT_PREEMPT_EN
      test_preempt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
